// File: rtl/smem_bck_retire_pkg.sv
// Shared definitions for the SMEM backward-extension tail: status codes and
// the recirculated token layout (field order matches the pipeline head).
package smem_bck_retire_pkg;

  localparam logic [5:0] BUBBLE  = 6'd0;
  localparam logic [5:0] BCK_INI = 6'd1;
  localparam logic [5:0] BCK_RUN = 6'd2;

  localparam int RN_FIELD_W = 10;
  localparam int TOKEN_W    = 146;

  typedef struct packed {
    logic [RN_FIELD_W-1:0] read_num;
    logic                  iteration_boundary;
    logic [63:0]           primary;
    logic [6:0]            backward_i;
    logic [6:0]            backward_j;
    logic [6:0]            new_size;
    logic [6:0]            new_last_size;
    logic [6:0]            forward_size_n;
    logic [6:0]            min_intv;
    logic [6:0]            current_wr_addr;
    logic [6:0]            current_rd_addr;
    logic [6:0]            mem_wr_addr;
  } token_t;

endpackage

// File: rtl/smem_token_fifo.sv
// Recirculation buffer: circular FIFO whose head is held in a register.
// 1-cycle push-to-valid latency; pushes at full and pops at empty are ignored.
module smem_token_fifo #(
  parameter int W     = 138,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic          push_en;
  logic          pop_en;

  assign valid      = (count != '0);
  assign push_en    = push && (count != (AW+1)'(DEPTH));
  assign pop_en     = pop && valid;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr_inc;
      count <= count + (AW+1)'(push_en) - (AW+1)'(pop_en);
      // Head register: next stored entry if one remains, otherwise the
      // incoming token when it lands in an empty (or emptying) buffer.
      if (pop_en) begin
        if (count > (AW+1)'(1)) dout <= mem[rd_ptr_inc];
        else if (push_en)       dout <= din;
      end else if (!valid && push_en) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/smem_bck_retire.sv
// SMEM backward tail: recirculates unfinished tokens, retires finished reads.
// 1-cycle latency to recir_valid/done_valid; backpressure via registered stall_req.
module smem_bck_retire
  import smem_bck_retire_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int READ_NUM_WIDTH = 10,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [5:0]                status_q,
  input  logic [READ_NUM_WIDTH-1:0] read_num_q,
  input  logic                      finish_sign_q,
  input  logic                      iteration_boundary_q,
  input  logic [63:0]               primary_q,
  input  logic [6:0]                backward_i_q,
  input  logic [6:0]                backward_j_q,
  input  logic [6:0]                new_size_q,
  input  logic [6:0]                new_last_size_q,
  input  logic [6:0]                forward_size_n_q,
  input  logic [6:0]                min_intv_q,
  input  logic [6:0]                current_wr_addr_q,
  input  logic [6:0]                current_rd_addr_q,
  input  logic [6:0]                mem_wr_addr_q,
  output logic                      stall_req,
  output logic                      recir_valid,
  input  logic                      recir_ready,
  output logic [TOKEN_W-1:0]        recir_token,
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic [READ_NUM_WIDTH-1:0] done_read_num,
  output logic [6:0]                done_mem_cnt,
  output logic [31:0]               retired_count
);

  token_t        tok;
  token_t        head;
  logic          accept;
  logic          push;
  logic          fin;
  logic          pop;
  logic          done_hs;
  logic          done_valid_nxt;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;

  assign accept = !stall && (status_q != BUBBLE);
  assign push   = accept && !finish_sign_q;
  assign fin    = accept && finish_sign_q;
  assign pop    = recir_valid && recir_ready;
  assign done_hs = done_valid && done_ready;

  // Pushes never meet a full buffer because stall already carries stall_req.
  assign count_nxt      = count + (AW+1)'(push) - (AW+1)'(pop);
  assign done_valid_nxt = fin || (done_valid && !done_ready);

  always_comb begin
    tok = {RN_FIELD_W'(read_num_q), iteration_boundary_q, primary_q,
           backward_i_q, backward_j_q, new_size_q, new_last_size_q,
           forward_size_n_q, min_intv_q, current_wr_addr_q,
           current_rd_addr_q, mem_wr_addr_q};
  end

  smem_token_fifo #(
    .W     ($bits(token_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (tok),
    .pop   (pop),
    .dout  (head),
    .valid (recir_valid),
    .count (count)
  );

  // Token occupies the low bits; the unused top of the bus is tied to zero.
  assign recir_token = TOKEN_W'(head);

  always_ff @(posedge clk) begin
    if (rst) begin
      done_valid    <= 1'b0;
      done_read_num <= '0;
      done_mem_cnt  <= '0;
      stall_req     <= 1'b0;
      retired_count <= '0;
    end else begin
      done_valid <= done_valid_nxt;
      if (fin) begin
        done_read_num <= read_num_q;
        done_mem_cnt  <= mem_wr_addr_q;
      end
      if (done_hs) retired_count <= retired_count + 32'd1;
      stall_req <= (count_nxt == (AW+1)'(DEPTH)) || done_valid_nxt;
    end
  end

endmodule

// File: tb/tb_smem_bck_retire.sv
// Directed bench for smem_bck_retire: queue-based reference model checked
// every cycle, plus literal expectations at each scenario step.
module tb_smem_bck_retire;
  import smem_bck_retire_pkg::*;

  localparam int DEPTH = 16;
  localparam int RNW   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_stall = 1'b0;
  logic        tb_bypass = 1'b0;
  logic        stall;
  logic [5:0]  status_q = BUBBLE;
  logic [RNW-1:0] read_num_q = '0;
  logic        finish_sign_q = 1'b0;
  logic        iteration_boundary_q = 1'b0;
  logic [63:0] primary_q = '0;
  logic [6:0]  backward_i_q = '0, backward_j_q = '0, new_size_q = '0;
  logic [6:0]  new_last_size_q = '0, forward_size_n_q = '0, min_intv_q = '0;
  logic [6:0]  current_wr_addr_q = '0, current_rd_addr_q = '0, mem_wr_addr_q = '0;
  logic        recir_ready = 1'b0;
  logic        done_ready = 1'b0;
  logic        stall_req, recir_valid, done_valid;
  logic [145:0] recir_token;
  logic [RNW-1:0] done_read_num;
  logic [6:0]  done_mem_cnt;
  logic [31:0] retired_count;

  int n_chk = 0;
  int n_fail = 0;

  // The global stall includes the block's own request unless bypassed.
  assign stall = tb_stall | (stall_req & ~tb_bypass);

  always #5 clk = ~clk;

  smem_bck_retire #(.DEPTH(DEPTH), .READ_NUM_WIDTH(RNW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .status_q(status_q),
    .read_num_q(read_num_q), .finish_sign_q(finish_sign_q),
    .iteration_boundary_q(iteration_boundary_q), .primary_q(primary_q),
    .backward_i_q(backward_i_q), .backward_j_q(backward_j_q),
    .new_size_q(new_size_q), .new_last_size_q(new_last_size_q),
    .forward_size_n_q(forward_size_n_q), .min_intv_q(min_intv_q),
    .current_wr_addr_q(current_wr_addr_q), .current_rd_addr_q(current_rd_addr_q),
    .mem_wr_addr_q(mem_wr_addr_q), .stall_req(stall_req),
    .recir_valid(recir_valid), .recir_ready(recir_ready),
    .recir_token(recir_token), .done_valid(done_valid),
    .done_ready(done_ready), .done_read_num(done_read_num),
    .done_mem_cnt(done_mem_cnt), .retired_count(retired_count)
  );

  // Reference model state
  logic [137:0] m_q[$];
  logic         m_done_vld = 1'b0;
  logic [9:0]   m_done_rn = '0;
  logic [6:0]   m_done_cnt = '0;
  logic [31:0]  m_ret = '0;
  logic         m_stall_req = 1'b0;
  bit           m_started = 1'b0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [137:0] cur_tok();
    return {10'(read_num_q), iteration_boundary_q, primary_q, backward_i_q,
            backward_j_q, new_size_q, new_last_size_q, forward_size_n_q,
            min_intv_q, current_wr_addr_q, current_rd_addr_q, mem_wr_addr_q};
  endfunction

  // Advances the model with the inputs sampled at this clock edge.
  task automatic model_step();
    logic stl, acc, hs;
    if (rst) begin
      m_q.delete();
      m_done_vld = 1'b0; m_done_rn = '0; m_done_cnt = '0;
      m_ret = '0; m_stall_req = 1'b0;
    end else begin
      stl = tb_stall | (m_stall_req & ~tb_bypass);
      acc = !stl && (status_q != BUBBLE);
      hs  = m_done_vld && done_ready;
      if (m_q.size() != 0 && recir_ready) void'(m_q.pop_front());
      if (acc && !finish_sign_q) m_q.push_back(cur_tok());
      if (hs) begin m_done_vld = 1'b0; m_ret = m_ret + 32'd1; end
      if (acc && finish_sign_q) begin
        m_done_vld = 1'b1; m_done_rn = 10'(read_num_q); m_done_cnt = mem_wr_addr_q;
      end
      m_stall_req = (m_q.size() == DEPTH) || m_done_vld;
    end
    m_started = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_tok(input logic [5:0] st, input logic [9:0] rn,
                         input logic fin, input logic [6:0] mw);
    status_q = st; read_num_q = rn; finish_sign_q = fin; mem_wr_addr_q = mw;
    iteration_boundary_q = 1'($urandom);
    primary_q = {$urandom, $urandom};
    backward_i_q = 7'($urandom); backward_j_q = 7'($urandom);
    new_size_q = 7'($urandom); new_last_size_q = 7'($urandom);
    forward_size_n_q = 7'($urandom); min_intv_q = 7'($urandom);
    current_wr_addr_q = 7'($urandom); current_rd_addr_q = 7'($urandom);
  endtask

  task automatic idle();
    status_q = BUBBLE; finish_sign_q = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_started) begin
      chk("recir_valid", 160'(recir_valid), 160'(m_q.size() != 0));
      if (m_q.size() != 0)
        chk("recir_token", 160'(recir_token), 160'({8'd0, m_q[0]}));
      chk("done_valid", 160'(done_valid), 160'(m_done_vld));
      if (m_done_vld) begin
        chk("done_read_num", 160'(done_read_num), 160'(m_done_rn));
        chk("done_mem_cnt", 160'(done_mem_cnt), 160'(m_done_cnt));
      end
      chk("stall_req", 160'(stall_req), 160'(m_stall_req));
      chk("retired_count", 160'(retired_count), 160'(m_ret));
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_recir_valid", 160'(recir_valid), 160'(0));
    chk("rst_done_valid", 160'(done_valid), 160'(0));
    chk("rst_stall_req", 160'(stall_req), 160'(0));
    chk("rst_retired", 160'(retired_count), 160'(0));
    chk("rst_token", 160'(recir_token), 160'(0));
    rst = 1'b0;

    // Three tokens streamed through with the head always ready
    recir_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_tok((i == 2) ? BCK_INI : BCK_RUN, 10'(i), 1'b0, 7'd0);
      tick();
      chk("stream_valid", 160'(recir_valid), 160'(1));
      chk("stream_rn", 160'(recir_token[137:128]), 160'(i));
      chk("stream_stall", 160'(stall_req), 160'(0));
    end
    idle();
    tick();
    chk("stream_drained", 160'(recir_valid), 160'(0));

    // Fill to DEPTH, then one pop under stall releases the request
    recir_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_tok(BCK_RUN, 10'(100 + i), 1'b0, 7'd0);
      tick();
    end
    chk("full_stall_req", 160'(stall_req), 160'(1));
    chk("full_model_cnt", 160'(m_q.size()), 160'(16));
    chk("full_head", 160'(recir_token[137:128]), 160'(100));
    tb_stall = 1'b1;
    recir_ready = 1'b1;
    set_tok(BCK_RUN, 10'd200, 1'b0, 7'd0);
    tick();
    chk("pop_stall_req", 160'(stall_req), 160'(0));
    chk("pop_model_cnt", 160'(m_q.size()), 160'(15));
    chk("pop_head", 160'(recir_token[137:128]), 160'(101));
    tb_stall = 1'b0;
    idle();
    for (int i = 0; i < 20; i++) if (m_q.size() != 0) tick();
    chk("drain_empty", 160'(m_q.size()), 160'(0));
    chk("drain_valid", 160'(recir_valid), 160'(0));

    // Finish token held in the result slot, then handed off
    recir_ready = 1'b0;
    set_tok(BCK_RUN, 10'd5, 1'b1, 7'd9);
    tick();
    idle();
    chk("fin_valid", 160'(done_valid), 160'(1));
    chk("fin_rn", 160'(done_read_num), 160'(5));
    chk("fin_cnt", 160'(done_mem_cnt), 160'(9));
    chk("fin_stall", 160'(stall_req), 160'(1));
    chk("fin_no_push", 160'(recir_valid), 160'(0));
    repeat (2) tick();
    chk("fin_held", 160'(done_valid), 160'(1));
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("hs_valid", 160'(done_valid), 160'(0));
    chk("hs_retired", 160'(retired_count), 160'(1));
    chk("hs_stall", 160'(stall_req), 160'(0));

    // Bubbles and stalled tokens are never consumed
    for (int i = 0; i < 4; i++) begin
      set_tok(BUBBLE, 10'($urandom), 1'($urandom), 7'($urandom));
      tick();
    end
    tb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_tok(BCK_RUN, 10'(40 + i), 1'(i), 7'(i));
      tick();
    end
    tb_stall = 1'b0;
    idle();
    chk("ign_cnt", 160'(m_q.size()), 160'(0));
    chk("ign_recir", 160'(recir_valid), 160'(0));
    chk("ign_done", 160'(done_valid), 160'(0));
    chk("ign_retired", 160'(retired_count), 160'(1));

    // Simultaneous push and pop at count 7
    for (int i = 0; i < 7; i++) begin
      set_tok(BCK_RUN, 10'(50 + i), 1'b0, 7'd0);
      tick();
    end
    chk("seven_cnt", 160'(m_q.size()), 160'(7));
    set_tok(BCK_RUN, 10'd60, 1'b0, 7'd0);
    recir_ready = 1'b1;
    tick();
    recir_ready = 1'b0;
    idle();
    chk("pp_cnt", 160'(m_q.size()), 160'(7));
    chk("pp_head", 160'(recir_token[137:128]), 160'(51));

    // Done handshake coinciding with a new finish
    set_tok(BCK_RUN, 10'd20, 1'b1, 7'd3);
    tick();
    chk("d20_rn", 160'(done_read_num), 160'(20));
    set_tok(BCK_INI, 10'd21, 1'b1, 7'd4);
    tb_bypass = 1'b1;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    idle();
    chk("swap_valid", 160'(done_valid), 160'(1));
    chk("swap_rn", 160'(done_read_num), 160'(21));
    chk("swap_cnt", 160'(done_mem_cnt), 160'(4));
    chk("swap_retired", 160'(retired_count), 160'(2));

    // Reach count 10 with the slot occupied, then reset mid-operation
    for (int i = 0; i < 3; i++) begin
      set_tok(BCK_RUN, 10'(70 + i), 1'b0, 7'd0);
      tick();
    end
    tb_bypass = 1'b0;
    idle();
    chk("pre_rst_cnt", 160'(m_q.size()), 160'(10));
    chk("pre_rst_done", 160'(done_valid), 160'(1));
    rst = 1'b1;
    recir_ready = 1'b1;
    done_ready = 1'b1;
    tick();
    rst = 1'b0;
    recir_ready = 1'b0;
    done_ready = 1'b0;
    chk("mid_rst_recir", 160'(recir_valid), 160'(0));
    chk("mid_rst_done", 160'(done_valid), 160'(0));
    chk("mid_rst_stall", 160'(stall_req), 160'(0));
    chk("mid_rst_retired", 160'(retired_count), 160'(0));
    chk("mid_rst_token", 160'(recir_token), 160'(0));
    chk("mid_rst_cnt", 160'(m_q.size()), 160'(0));

    // Buffer is usable again after reset
    set_tok(BCK_INI, 10'd9, 1'b0, 7'd0);
    tick();
    idle();
    chk("post_rst_valid", 160'(recir_valid), 160'(1));
    chk("post_rst_rn", 160'(recir_token[137:128]), 160'(9));
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/smem_bck_retire.md
Name: smem_bck_retire

Overview:
Tail stage of the SMEM backward-extension pipeline. It receives the per-read token stream produced by the stage-2 j/i control stage and its downstream stages. Unfinished tokens are buffered in a recirculation FIFO and handed back to the pipeline head. Finished reads are retired through a single-entry result slot with a valid/ready handshake. It drives a registered stall request that is OR-ed into the global pipeline stall.

Parameters:
DEPTH, 16, recirculation FIFO entries (power of 2, >=4)
READ_NUM_WIDTH, 10, read-number width (matches codebase macro)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
stall  in  1  global pipeline stall (includes this block's stall_req)
status_q  in  6  token status: BCK_INI, BCK_RUN or BUBBLE
read_num_q  in  READ_NUM_WIDTH  read id
finish_sign_q  in  1  read finished (j bound reached with new_size==0)
iteration_boundary_q  in  1  i exhausted
primary_q  in  64  primary length
backward_i_q, backward_j_q  in  7 each  loop indices
new_size_q, new_last_size_q, forward_size_n_q, min_intv_q  in  7 each  sizes
current_wr_addr_q, current_rd_addr_q, mem_wr_addr_q  in  7 each  buffer addresses
stall_req  out  1  registered stall request
recir_valid  out  1  FIFO head valid
recir_ready  in  1  pipeline head accepts recirculated token
recir_token  out  146  {read_num,iteration_boundary,primary,i,j,new_size,new_last_size,forward_size_n,min_intv,cur_wr,cur_rd,mem_wr}; fields zero-extended to 10 bits for read_num
done_valid  out  1  retired read available
done_ready  in  1  consumer accepts retired read
done_read_num  out  READ_NUM_WIDTH  retired read id
done_mem_cnt  out  7  SMEM entries written (mem_wr_addr_q at finish)
retired_count  out  32  statistic: completed done handshakes

Behaviour:
- accept = !stall && status_q != BUBBLE. BUBBLE or stalled inputs are never consumed, whatever their other fields.
- accept && !finish_sign_q: push the token into the FIFO the same cycle. BCK_INI and BCK_RUN are treated identically.
- accept && finish_sign_q: load the done slot next cycle (done_valid=1, done_read_num, done_mem_cnt). No FIFO push.
- FIFO: recir_valid = (count!=0); recir_token = head entry, registered (no fall-through). Pop on recir_valid && recir_ready.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Done slot: cleared on done_valid && done_ready. A same-cycle clear and new load keeps done_valid=1 with the new contents.
- retired_count increments on each done handshake and wraps at 2^32.
- stall_req <= (count_next == DEPTH) | done_valid_next. It is registered, so push never happens at full and a finish never overwrites a held slot. No skid is needed because stall already contains stall_req.
- Latency: input to recir_valid is 1 cycle; input to done_valid is 1 cycle.
- Reset (also mid-operation): count, pointers, done_valid, stall_req, retired_count, done_* and recir_token are 0. All FIFO contents are discarded.
- recir_ready and done_ready are ignored while rst=1.

Decomposition:
- Status codes BCK_INI, BCK_RUN, BUBBLE and the token field order/width come from the shared pipeline_head.vh. The field order is the recir_token concatenation given in Ports.
- Sub-module smem_token_fifo (parameterised width/depth, registered output, count output) holds the recirculation buffer.
- Top level holds accept logic, the done slot, the stall register and the counter.

Test Plan:
- Reset, then 3 BCK_RUN tokens (read_num 1,2,3, finish=0) with recir_ready=1 -> recir_valid from the cycle after the first token; tokens appear in order 1,2,3; stall_req stays 0.
- recir_ready=0, push 16 tokens -> stall_req=1 the cycle after the 16th. Assert stall next cycle, raise recir_ready for 1 cycle -> stall_req drops next cycle; count goes 16->15.
- Finish token read_num=5, mem_wr_addr_q=9, done_ready=0 -> done_valid=1, done_read_num=5, done_mem_cnt=9, stall_req=1. done_ready=1 -> done_valid=0, retired_count=1.
- status_q=BUBBLE for 4 cycles with random fields, and separately stall=1 with valid tokens -> no push, no retire, count constant.
- Simultaneous push and pop at count=7 -> count stays 7. Done handshake plus new finish in the same cycle -> done_valid stays 1 with the new read_num; retired_count +1.
- rst pulsed with count=10 and done_valid=1 -> next cycle count=0, recir_valid=0, done_valid=0, stall_req=0, retired_count=0.
